// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-store boot controller.
//   - state_e          : controller phases (clear, load, run)
//   - DEPTH / DATA_W   : store geometry
//   - IDX_W / CNT_W    : word-index and load-count widths
//   - PC_IDX_HI/LO     : byte-address bits that select a word
//   - PC_TOP_LO        : lowest byte-address bit that lies beyond the store
package imem_pkg;

  localparam int DEPTH     = 32;
  localparam int DATA_W    = 32;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int CNT_W     = IDX_W + 1;
  localparam int PC_W      = 32;
  localparam int PC_IDX_LO = 2;
  localparam int PC_IDX_HI = PC_IDX_LO + IDX_W - 1;
  localparam int PC_TOP_LO = PC_IDX_HI + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/imem_store.sv
// imem_store: DEPTH x DATA_W instruction RAM.
//   clk_i    : write clock
//   we_i     : write enable, sampled on rising edge
//   waddr_i  : write word index
//   wdata_i  : write data
//   raddr_i  : read word index (combinational read)
//   rdata_o  : read data
module imem_store
  import imem_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Synchronous write port; contents are initialised by the controller's clear pass.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: clears the instruction store, loads a program from a
// valid/ready word stream, then serves combinational CPU fetches.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   load_req_i           : request clear-and-reload (acted on only while running)
//   ld_valid_i/ld_data_i/ld_last_i, ld_ready_o : loader word stream
//   cpu_pc_i, cpu_instr_o, cpu_stall_o         : CPU fetch path
//   done_o               : program loaded, CPU running
//   count_o, ovf_o       : words written by last load, store filled without last
//   pc_err_o             : fetch address lies beyond the store
module imem_boot_ctrl
  import imem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic [PC_W-1:0]   cpu_pc_i,
  output logic [DATA_W-1:0] cpu_instr_o,
  output logic              cpu_stall_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o,
  output logic              pc_err_o
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              accept_s;
  logic              we_s;
  logic [IDX_W-1:0]  waddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [IDX_W-1:0]  raddr_s;
  logic [DATA_W-1:0] rdata_s;
  logic              pc_lsb_unused_s;

  // Byte offset within a word is ignored: misaligned fetches truncate to the word.
  assign pc_lsb_unused_s = ^cpu_pc_i[PC_IDX_LO-1:0];
  assign raddr_s         = cpu_pc_i[PC_IDX_HI:PC_IDX_LO];
  assign pc_err_o        = |cpu_pc_i[PC_W-1:PC_TOP_LO];
  assign accept_s        = (state_q == ST_LOAD) && ld_valid_i;
  assign count_o         = count_q;
  assign ovf_o           = ovf_q;

  imem_store u_store (
    .clk_i   (clk_i),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .raddr_i (raddr_s),
    .rdata_o (rdata_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_ptr_q == LAST_IDX) state_d = ST_LOAD;
        else                       state_d = ST_CLEAR;
      end
      ST_LOAD: begin
        // Either an explicit last word or a full store ends the load.
        if (accept_s && (ld_last_i || (wr_ptr_q == LAST_IDX))) state_d = ST_RUN;
        else                                                   state_d = ST_LOAD;
      end
      ST_RUN: begin
        if (load_req_i) state_d = ST_CLEAR;
        else            state_d = ST_RUN;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Next values for clear/write pointers, load count and overflow flag.
  always_comb begin
    clr_ptr_d = clr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + IDX_W'(1);
      end
      ST_LOAD: begin
        if (accept_s) begin
          wr_ptr_d = wr_ptr_q + IDX_W'(1);
          count_d  = count_q + CNT_W'(1);
          if (!ld_last_i && (wr_ptr_q == LAST_IDX)) ovf_d = 1'b1;
          else                                      ovf_d = ovf_q;
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      ST_RUN: begin
        // Entering the clear pass starts a fresh load record.
        if (load_req_i) begin
          clr_ptr_d = {IDX_W{1'b0}};
          wr_ptr_d  = {IDX_W{1'b0}};
          count_d   = {CNT_W{1'b0}};
          ovf_d     = 1'b0;
        end else begin
          ovf_d = ovf_q;
        end
      end
      default: begin
        clr_ptr_d = {IDX_W{1'b0}};
        wr_ptr_d  = {IDX_W{1'b0}};
        count_d   = {CNT_W{1'b0}};
        ovf_d     = 1'b0;
      end
    endcase
  end

  // Pointer, count and overflow registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_ptr_q <= {IDX_W{1'b0}};
      wr_ptr_q  <= {IDX_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      clr_ptr_q <= clr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Outputs and store write-port mux (clear writes zero, load writes stream data).
  always_comb begin
    ld_ready_o  = 1'b0;
    cpu_stall_o = 1'b1;
    done_o      = 1'b0;
    cpu_instr_o = {DATA_W{1'b0}};
    we_s        = 1'b0;
    waddr_s     = clr_ptr_q;
    wdata_s     = {DATA_W{1'b0}};
    case (state_q)
      ST_CLEAR: begin
        we_s    = ~rst_i;
        waddr_s = clr_ptr_q;
      end
      ST_LOAD: begin
        ld_ready_o = 1'b1;
        we_s       = accept_s && !rst_i;
        waddr_s    = wr_ptr_q;
        wdata_s    = ld_data_i;
      end
      ST_RUN: begin
        cpu_stall_o = 1'b0;
        done_o      = 1'b1;
        if (pc_err_o) cpu_instr_o = {DATA_W{1'b0}};
        else          cpu_instr_o = rdata_s;
      end
      default: begin
        cpu_stall_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_req_i;
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        ld_last_i;
  logic        ld_ready_o;
  logic [31:0] cpu_pc_i;
  logic [31:0] cpu_instr_o;
  logic        cpu_stall_o;
  logic        done_o;
  logic [5:0]  count_o;
  logic        ovf_o;
  logic        pc_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: expected store image and load record.
  logic [31:0] m_mem [32];
  int          m_count;
  bit          m_ovf;
  bit          m_done;
  logic [31:0] q_data [$];

  imem_boot_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_req_i  (load_req_i),
    .ld_valid_i  (ld_valid_i),
    .ld_data_i   (ld_data_i),
    .ld_last_i   (ld_last_i),
    .ld_ready_o  (ld_ready_o),
    .cpu_pc_i    (cpu_pc_i),
    .cpu_instr_o (cpu_instr_o),
    .cpu_stall_o (cpu_stall_o),
    .done_o      (done_o),
    .count_o     (count_o),
    .ovf_o       (ovf_o),
    .pc_err_o    (pc_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_count = 0;
    m_ovf   = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; load_req_i = 1'b0; ld_valid_i = 1'b0; ld_last_i = 1'b0; ld_data_i = 32'h0;
    step();
    step();
    rst_i = 1'b0;
    model_clear();
  endtask

  // Clear pass: expect exactly 32 edges of stall with ready low, loader noise ignored.
  task automatic wait_clear(input bit noisy);
    int edges = 0;
    bit seen  = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      n_cmp++; if (ld_ready_o !== 1'b0) begin n_bad++; $display("FAIL clr_ready: got %b want 0 (cycle %0d)", ld_ready_o, c); end
      n_cmp++; if (cpu_stall_o !== 1'b1) begin n_bad++; $display("FAIL clr_stall: got %b want 1 (cycle %0d)", cpu_stall_o, c); end
      n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL clr_done: got %b want 0 (cycle %0d)", done_o, c); end
      if (noisy) begin
        ld_valid_i = c[0];
        ld_data_i  = 32'hDEAD0000 | 32'(c);
        ld_last_i  = 1'b1;
        load_req_i = 1'($urandom_range(0, 1));
      end
      step();
      edges = c;
      if (ld_ready_o === 1'b1) seen = 1'b1;
    end
    ld_valid_i = 1'b0; ld_last_i = 1'b0; load_req_i = 1'b0;
    n_cmp++; if (!seen || edges != 32) begin n_bad++; $display("FAIL clr_len: got %0d edges (seen=%0d) want 32", edges, seen); end
  endtask

  // Stream q_data[0..n-1]; last flag on index last_at (-1 = none); optional bubbles.
  task automatic load_stream(input int n, input int last_at, input bit bubbles);
    int idx    = 0;
    int budget = 300;
    bit v;
    while (idx < n && !m_done && budget > 0) begin
      v = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
      ld_valid_i = v;
      ld_data_i  = q_data[idx];
      ld_last_i  = (idx == last_at);
      load_req_i = 1'($urandom_range(0, 1));
      n_cmp++; if (ld_ready_o !== 1'b1) begin n_bad++; $display("FAIL ld_ready: got %b want 1 (word %0d)", ld_ready_o, idx); end
      n_cmp++; if (cpu_stall_o !== 1'b1) begin n_bad++; $display("FAIL ld_stall: got %b want 1 (word %0d)", cpu_stall_o, idx); end
      n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL ld_done: got %b want 0 (word %0d)", done_o, idx); end
      step();
      if (v) begin
        m_mem[m_count] = q_data[idx];
        m_count++;
        if (idx == last_at) m_done = 1'b1;
        else if (m_count == 32) begin m_ovf = 1'b1; m_done = 1'b1; end
        idx++;
      end
      budget--;
    end
    ld_valid_i = 1'b0; ld_last_i = 1'b0; load_req_i = 1'b0;
    n_cmp++; if (budget == 0) begin n_bad++; $display("FAIL ld_budget: got budget exhausted want stream done"); end
    n_cmp++; if (count_o !== 6'(m_count)) begin n_bad++; $display("FAIL ld_count: got %0d want %0d", count_o, m_count); end
    n_cmp++; if (ovf_o !== m_ovf) begin n_bad++; $display("FAIL ld_ovf: got %b want %b", ovf_o, m_ovf); end
    n_cmp++; if (done_o !== m_done) begin n_bad++; $display("FAIL ld_end_done: got %b want %b", done_o, m_done); end
    n_cmp++; if (cpu_stall_o !== !m_done) begin n_bad++; $display("FAIL ld_end_stall: got %b want %b", cpu_stall_o, !m_done); end
  endtask

  // Read every word back through the fetch port with a random byte offset.
  task automatic check_contents();
    for (int i = 0; i < 32; i++) begin
      cpu_pc_i = 32'(i * 4) | 32'($urandom_range(0, 3));
      step();
      n_cmp++; if (cpu_instr_o !== m_mem[i]) begin n_bad++; $display("FAIL rd_word: pc %h got %h want %h", cpu_pc_i, cpu_instr_o, m_mem[i]); end
      n_cmp++; if (pc_err_o !== 1'b0) begin n_bad++; $display("FAIL rd_pcerr: pc %h got %b want 0", cpu_pc_i, pc_err_o); end
    end
    n_cmp++; if (cpu_stall_o !== 1'b0 || done_o !== 1'b1) begin n_bad++; $display("FAIL rd_run: got stall=%b done=%b want 0/1", cpu_stall_o, done_o); end
    cpu_pc_i = 32'h0;
  endtask

  task automatic test_reset();
    cpu_pc_i = 32'h0;
    do_reset();
    n_cmp++; if (ld_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", ld_ready_o); end
    n_cmp++; if (cpu_stall_o !== 1'b1) begin n_bad++; $display("FAIL rst_stall: got %b want 1", cpu_stall_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done_o); end
    n_cmp++; if (count_o !== 6'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count_o); end
    n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", ovf_o); end
    n_cmp++; if (cpu_instr_o !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", cpu_instr_o); end
    n_cmp++; if (pc_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_pcerr0: got %b want 0", pc_err_o); end
    cpu_pc_i = 32'h100;
    #1;
    n_cmp++; if (pc_err_o !== 1'b1) begin n_bad++; $display("FAIL rst_pcerr1: got %b want 1", pc_err_o); end
    cpu_pc_i = 32'h0;
  endtask

  task automatic test_basic();
    do_reset();
    wait_clear(1'b1);
    q_data.delete();
    q_data.push_back(32'h20010005);
    q_data.push_back(32'h20020003);
    q_data.push_back(32'h00221820);
    load_stream(3, 2, 1'b0);
    cpu_pc_i = 32'd0;  #1;
    n_cmp++; if (cpu_instr_o !== 32'h20010005) begin n_bad++; $display("FAIL basic_pc0: got %h want 20010005", cpu_instr_o); end
    cpu_pc_i = 32'd4;  #1;
    n_cmp++; if (cpu_instr_o !== 32'h20020003) begin n_bad++; $display("FAIL basic_pc4: got %h want 20020003", cpu_instr_o); end
    cpu_pc_i = 32'd8;  #1;
    n_cmp++; if (cpu_instr_o !== 32'h00221820) begin n_bad++; $display("FAIL basic_pc8: got %h want 00221820", cpu_instr_o); end
    cpu_pc_i = 32'd12; #1;
    n_cmp++; if (cpu_instr_o !== 32'h0) begin n_bad++; $display("FAIL basic_pc12: got %h want 0", cpu_instr_o); end
    n_cmp++; if (count_o !== 6'd3 || ovf_o !== 1'b0) begin n_bad++; $display("FAIL basic_cnt: got %0d/%b want 3/0", count_o, ovf_o); end
    check_contents();
  endtask

  task automatic test_bubbles();
    do_reset();
    wait_clear(1'b1);
    q_data.delete();
    for (int i = 0; i < 6; i++) q_data.push_back($urandom);
    load_stream(6, 5, 1'b1);
    check_contents();
  endtask

  task automatic test_overflow();
    do_reset();
    wait_clear(1'b0);
    q_data.delete();
    for (int i = 0; i < 33; i++) q_data.push_back(32'(i + 1));
    load_stream(33, -1, 1'b0);
    n_cmp++; if (count_o !== 6'd32 || ovf_o !== 1'b1) begin n_bad++; $display("FAIL ovf_flags: got %0d/%b want 32/1", count_o, ovf_o); end
    cpu_pc_i = 32'd124; #1;
    n_cmp++; if (cpu_instr_o !== 32'd32) begin n_bad++; $display("FAIL ovf_pc124: got %h want 20", cpu_instr_o); end
    ld_valid_i = 1'b1; ld_data_i = 32'd33; ld_last_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (ld_ready_o !== 1'b0) begin n_bad++; $display("FAIL ovf_ready: got %b want 0", ld_ready_o); end
      step();
    end
    ld_valid_i = 1'b0;
    n_cmp++; if (count_o !== 6'd32 || cpu_instr_o !== 32'd32) begin n_bad++; $display("FAIL ovf_33rd: got %0d/%h want 32/20", count_o, cpu_instr_o); end
    check_contents();
  endtask

  task automatic test_pc_err();
    cpu_pc_i = 32'h80; #1;
    n_cmp++; if (pc_err_o !== 1'b1 || cpu_instr_o !== 32'h0) begin n_bad++; $display("FAIL pcerr_80: got %b/%h want 1/0", pc_err_o, cpu_instr_o); end
    cpu_pc_i = 32'hFFFFFFFC; #1;
    n_cmp++; if (pc_err_o !== 1'b1 || cpu_instr_o !== 32'h0) begin n_bad++; $display("FAIL pcerr_top: got %b/%h want 1/0", pc_err_o, cpu_instr_o); end
    cpu_pc_i = 32'h7E; #1;
    n_cmp++; if (pc_err_o !== 1'b0 || cpu_instr_o !== m_mem[31]) begin n_bad++; $display("FAIL pcerr_7e: got %b/%h want 0/%h", pc_err_o, cpu_instr_o, m_mem[31]); end
    cpu_pc_i = 32'h0;
  endtask

  task automatic test_reload();
    load_req_i = 1'b1;
    step();
    load_req_i = 1'b0;
    n_cmp++; if (cpu_stall_o !== 1'b1 || done_o !== 1'b0) begin n_bad++; $display("FAIL rl_stall: got %b/%b want 1/0", cpu_stall_o, done_o); end
    n_cmp++; if (count_o !== 6'd0 || ovf_o !== 1'b0) begin n_bad++; $display("FAIL rl_zero: got %0d/%b want 0/0", count_o, ovf_o); end
    model_clear();
    wait_clear(1'b0);
    q_data.delete();
    q_data.push_back(32'hAAAA0001);
    load_stream(1, 0, 1'b0);
    cpu_pc_i = 32'd4; #1;
    n_cmp++; if (cpu_instr_o !== 32'h0) begin n_bad++; $display("FAIL rl_pc4: got %h want 0", cpu_instr_o); end
    cpu_pc_i = 32'd0; #1;
    n_cmp++; if (cpu_instr_o !== 32'hAAAA0001) begin n_bad++; $display("FAIL rl_pc0: got %h want aaaa0001", cpu_instr_o); end
    check_contents();
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    wait_clear(1'b0);
    q_data.delete();
    q_data.push_back(32'h11111111);
    q_data.push_back(32'h22222222);
    load_stream(2, -1, 1'b0);
    rst_i = 1'b1; ld_valid_i = 1'b1; ld_data_i = 32'h99999999; ld_last_i = 1'b1;
    step();
    rst_i = 1'b0; ld_valid_i = 1'b0; ld_last_i = 1'b0;
    model_clear();
    n_cmp++; if (count_o !== 6'd0 || done_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst: got %0d/%b want 0/0", count_o, done_o); end
    n_cmp++; if (ld_ready_o !== 1'b0 || cpu_stall_o !== 1'b1) begin n_bad++; $display("FAIL mid_rst_rdy: got %b/%b want 0/1", ld_ready_o, cpu_stall_o); end
    wait_clear(1'b0);
    q_data.delete();
    q_data.push_back(32'h33333333);
    load_stream(1, 0, 1'b0);
    cpu_pc_i = 32'd4; #1;
    n_cmp++; if (cpu_instr_o !== 32'h0) begin n_bad++; $display("FAIL mid_pc4: got %h want 0", cpu_instr_o); end
    check_contents();
  endtask

  initial begin
    rst_i = 1'b1; load_req_i = 1'b0; ld_valid_i = 1'b0; ld_data_i = 32'h0; ld_last_i = 1'b0; cpu_pc_i = 32'h0;
    test_reset();
    test_basic();
    test_bubbles();
    test_overflow();
    test_pc_err();
    test_reload();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot/reload controller for the single-cycle CPU's 32-word instruction store. It owns the instruction RAM, clears it, loads a program from a valid/ready word stream, then releases the CPU. Once released it serves combinational fetches by PC, holding the CPU in stall during any clear or load. It sits between the testbench/host loader and the CPU fetch path, and replaces file-based initialisation with a run-time load.

## Interface
- DEPTH, 32, instruction words held; power of two.
- DATA_W, 32, instruction width.
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- load_req_i  in  1  request a clear-and-reload; honoured only in RUN.
- ld_valid_i  in  1  loader word valid.
- ld_data_i  in  DATA_W  loader instruction word.
- ld_last_i  in  1  marks the final word of the program; qualified by ld_valid_i.
- ld_ready_o  out  1  controller accepts a word this cycle.
- cpu_pc_i  in  32  fetch byte address from the CPU.
- cpu_instr_o  out  DATA_W  fetched instruction.
- cpu_stall_o  out  1  CPU must hold its PC and state.
- done_o  out  1  program loaded; high in RUN.
- count_o  out  6  words written by the last load, 0..32.
- ovf_o  out  1  the load filled DEPTH words without seeing ld_last_i.
- pc_err_o  out  1  cpu_pc_i is beyond the store.

## Operation
- States: CLEAR, LOAD, RUN. Reset enters CLEAR.
- CLEAR: writes 0 to word clr_ptr each cycle, clr_ptr counting 0..DEPTH-1. After the write to word DEPTH-1, go to LOAD. Entry zeroes clr_ptr, wr_ptr, count_o and ovf_o.
- LOAD: ld_ready_o=1.
  - On ld_valid_i&&ld_ready_o, write ld_data_i to word wr_ptr, then increment wr_ptr and count_o.
  - If the accepted word has ld_last_i=1, go to RUN.
  - If the accepted word is at wr_ptr==DEPTH-1 and ld_last_i=0, go to RUN and set ovf_o=1. Loader words after that are not accepted.
- RUN:
  - cpu_stall_o=0 and done_o=1.
  - cpu_instr_o = mem[cpu_pc_i[6:2]], combinational on cpu_pc_i. cpu_pc_i[1:0] is ignored, so misaligned addresses truncate like /4.
  - load_req_i=1 goes to CLEAR.
- Outside RUN: cpu_stall_o=1, done_o=0, cpu_instr_o=0. load_req_i is ignored in CLEAR and LOAD.
- pc_err_o = (cpu_pc_i[31:7]!=0), combinational in every state. When pc_err_o=1, cpu_instr_o=0 even in RUN.
- Words not written by a load read as 0 because of the CLEAR pass. 0 decodes as a NOP/sll to the CPU.
- Reset values: ld_ready_o=0, cpu_stall_o=1, done_o=0, count_o=0, ovf_o=0, cpu_instr_o=0. pc_err_o follows cpu_pc_i.
- Reset mid-LOAD or mid-CLEAR discards progress and restarts CLEAR at word 0. Partially loaded words are rezeroed.

## Timing
- CLEAR takes exactly DEPTH cycles. ld_ready_o rises on the cycle after the write to word DEPTH-1, i.e. cycle DEPTH+1 after reset deasserts.
- The loader may hold ld_valid_i with ld_ready_o low; nothing is accepted until ready.
- A word accepted at edge N is readable from edge N onward.
- If the last word is accepted at edge N, at edge N: state=RUN, cpu_stall_o=0, done_o=1. cpu_instr_o reflects the new contents in that same cycle.
- load_req_i sampled high at edge N in RUN: cpu_stall_o=1 from edge N, and the clear of word 0 happens at edge N+1.
- count_o and ovf_o are registered and update at the accepting edge. They hold through RUN.
- rst_i high overrides every other input at the same edge.

## Structure
- Package imem_pkg holds:
  - the state enum (CLEAR, LOAD, RUN);
  - DEPTH, DATA_W and the derived index width (5);
  - the PC word-index slice bounds.
- Sub-module imem_store is the DEPTH×DATA_W RAM: one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
- imem_boot_ctrl holds the FSM, clr_ptr, wr_ptr, count_o, ovf_o, and the write-port mux (CLEAR writes 0/clr_ptr; LOAD writes ld_data_i/wr_ptr).

## Test plan
- Reset, then 3 words 0x20010005, 0x20020003, 0x00221820 with last on the third:
  - ld_ready_o rises at cycle 33;
  - done_o=1 at the edge the third word is accepted;
  - pc 0/4/8 returns the three words, pc 12 returns 0;
  - count_o=3, ovf_o=0.
- Backpressure and bubbles: ld_valid_i toggles 1,0,1 during CLEAR.
  - No word is accepted before LOAD.
  - Bubbles in LOAD do not advance wr_ptr.
- Overflow: stream 33 words (value = index+1) without last.
  - RUN is entered after 32 words, count_o=32, ovf_o=1.
  - pc 124 returns 32; the 33rd word is never accepted.
- Reload: in RUN, pulse load_req_i, then load 1 word 0xAAAA0001 with last.
  - cpu_stall_o=1 for 32 clear cycles plus the load.
  - pc 4 then reads 0, since the old contents were cleared.
- Reset mid-LOAD after 2 words: rst_i is high for one edge.
  - CLEAR restarts, count_o=0, done_o=0.
  - A subsequent 1-word load leaves pc 4 reading 0.
- pc_err: in RUN, pc=0x80 and pc=0xFFFFFFFC give pc_err_o=1 and cpu_instr_o=0. pc=0x7E reads word 31.
